spi_pixel_bridge: RTL and testbench
===================================

SPI_PIXEL_BRIDGE -- requirements
Module: spi_pixel_bridge

Interface
REQ-001 Parameter: NUM_REGS, 8, count of 8-bit config registers, 1..128.
REQ-002 Parameter: NUM_CH, 8, count of 8-bit readback result channels, 1..256.
REQ-003 Parameter: BYTES_PER_PIX, 6, SPI bytes packed per streamed pixel, 1..8.
REQ-004 Parameter: FRAME_W, 640, pixels per line.
REQ-005 Parameter: FRAME_H, 480, lines per frame.
REQ-006 Port: clk_p  in  1  single clock; all logic on its rising edge.
REQ-007 Port: rst_p  in  1  reset, asynchronous, active-high.
REQ-008 Port: css  in  1  SPI transaction active (high) / idle (low).
REQ-009 Port: byte_rdy  in  1  one-cycle strobe, byte_dat valid.
REQ-010 Port: byte_dat  in  8  received SPI byte.
REQ-011 Port: ch_dat  in  NUM_CH*8  result channels, channel k at [k*8+:8].
REQ-012 Port: feed_dat  out  8  byte returned on the next SPI byte.
REQ-013 Port: pix_valid  out  1  one-cycle pixel strobe.
REQ-014 Port: pix_dat  out  BYTES_PER_PIX*8  packed pixel, first received byte in MSBs.
REQ-015 Port: pix_x / pix_y  out  $clog2(FRAME_W) / $clog2(FRAME_H)  coordinate of the pixel most recently strobed.
REQ-016 Port: frame_done  out  1  one-cycle pulse with the last pixel of a frame.
REQ-017 Port: screen_rst  out  1  SPI-controlled frame reset, active-high.
REQ-018 Port: kgate  out  1  high while in STREAM state.
REQ-019 Port: reg_q  out  NUM_REGS*8  config register contents; reg 0 = readback channel select.

Function
REQ-020 FSM states SHALL be IDLE, CMD1, CMD2, DONE, STREAM; css low forces IDLE on the next edge and clears the byte counter and shift register, regardless of state.
REQ-021 byte_rdy in IDLE SHALL store opcode and go CMD1; in CMD1 store operand A and go CMD2; in CMD2 execute and go DONE (or STREAM); in DONE bytes SHALL be ignored.
REQ-022 Opcode 0x81, in CMD1: feed_dat SHALL become reg[A] when A<NUM_REGS, else 0x00, one cycle after byte_rdy.
REQ-023 Opcode 0x80, in CMD2: reg[A] <= byte when A<NUM_REGS; out-of-range writes are dropped.
REQ-024 Opcode 0x55, in CMD2: enter STREAM, kgate=1; 0x40: screen_rst<=0; 0x41: screen_rst<=1; other opcodes: no effect.
REQ-025 In command states feed_dat SHALL be 0xFF after each byte except as REQ-022 specifies.
REQ-026 In STREAM each byte SHALL shift into pix_dat staging; on the BYTES_PER_PIX-th byte pix_valid SHALL pulse exactly one cycle later with the full word; the counter wraps to 0.
REQ-027 In STREAM feed_dat SHALL be ch_dat channel reg[0] registered on each byte_rdy; reg[0]>=NUM_CH yields 0x00.
REQ-028 On each pix_valid pix_x SHALL advance; at FRAME_W-1 it wraps to 0 and pix_y advances; at (FRAME_W-1, FRAME_H-1) both wrap to 0 and frame_done pulses together with that pix_valid.
REQ-029 While screen_rst=1, pix_x/pix_y SHALL be held at 0 and frame_done SHALL stay 0; pix_valid still strobes.
REQ-030 byte_rdy coincident with css low SHALL be discarded; a partial pixel at css deassertion is discarded without pix_valid.
REQ-031 Registers and screen_rst SHALL persist across transactions.

Reset
REQ-032 rst_p high SHALL asynchronously force: state IDLE, reg_q=0, feed_dat=0xFF, pix_valid=0, pix_dat=0, pix_x=0, pix_y=0, frame_done=0, screen_rst=0, kgate=0.
REQ-033 Reset mid-stream SHALL abandon the partial pixel; the first pixel after release is (0,0).

Configuration
REQ-034 Macro SPI_PIXEL_BRIDGE_CSUM_EN defined: 8-bit XOR of all STREAM bytes, cleared on entering STREAM and on reset, readable via 0x81 with A=0xFE.
REQ-035 Macro undefined: no checksum logic; A=0xFE behaves as out-of-range (returns 0x00).

Verification
REQ-036 Write 0x80,0x03,0xA5 then 0x81,0x03 -> reg_q[31:24]=0xA5; feed_dat=0xA5 one cycle after second byte.
REQ-037 0x55,0,0 then 12 bytes 0x01..0x0C (BYTES_PER_PIX=6) -> two pix_valid pulses, pix_dat 0x010203040506 then 0x0708090A0B0C, pix_x 0 then 1.
REQ-038 FRAME_W=4, FRAME_H=2, stream 8 pixels -> frame_done only with 8th pixel; coordinates return to (0,0) on 9th.
REQ-039 css low after 3 of 6 stream bytes -> no pix_valid, kgate=0; next 0x55 stream yields pixel from new bytes only.
REQ-040 reg[0]=2, ch_dat channel 2=0x3C, stream bytes -> feed_dat=0x3C; reg[0]=9 with NUM_CH=8 -> 0x00.
REQ-041 CSUM_EN: stream 0x0F,0xF0,0x33 -> read A=0xFE gives 0xCC; macro off -> 0x00.

Source files
------------

// File: rtl/spi_pixel_bridge_if.sv
// SPI byte-level link between the SPI shifter and spi_pixel_bridge.
// The master drives the transaction/byte strobes; the slave returns feed_dat.
interface spi_pixel_bridge_if;
  logic       css;
  logic       byte_rdy;
  logic [7:0] byte_dat;
  logic [7:0] feed_dat;

  modport master (
    output css, byte_rdy, byte_dat,
    input  feed_dat
  );

  modport slave (
    input  css, byte_rdy, byte_dat,
    output feed_dat
  );
endinterface

// File: rtl/spi_pixel_bridge.sv
// SPI command decoder with config registers and a byte-to-pixel stream packer.
// Optional XOR stream checksum (read at 0xFE) when SPI_PIXEL_BRIDGE_CSUM_EN is defined.
module spi_pixel_bridge #(
  parameter int NUM_REGS      = 8,
  parameter int NUM_CH        = 8,
  parameter int BYTES_PER_PIX = 6,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  localparam int PW = BYTES_PER_PIX * 8,
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic                 clk_p,
  input  logic                 rst_p,
  spi_pixel_bridge_if.slave    spi,
  input  logic [NUM_CH*8-1:0]  ch_dat,
  output logic                 pix_valid,
  output logic [PW-1:0]        pix_dat,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 frame_done,
  output logic                 screen_rst,
  output logic                 kgate,
  output logic [NUM_REGS*8-1:0] reg_q
);

  typedef enum logic [2:0] {
    IDLE, CMD1, CMD2, DONE, STREAM
  } state_t;

  state_t               r_state;
  logic [7:0]           r_op;
  logic [7:0]           r_a;
  logic [7:0]           r_feed;
  logic [NUM_REGS*8-1:0] r_regs;
  logic [PW-1:0]        r_sh;
  logic [3:0]           r_cnt;
  logic                 r_pv;
  logic [PW-1:0]        r_pd;
  logic [XW-1:0]        r_px;
  logic [YW-1:0]        r_py;
  logic [XW-1:0]        r_nx;
  logic [YW-1:0]        r_ny;
  logic                 r_fd;
  logic                 r_scr;
  logic                 r_kgate;
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
  logic [7:0]           r_csum;
`endif

  logic [7:0]    w_rd;
  logic [7:0]    w_ch;
  logic [PW-1:0] w_sh;
  logic          w_last_x;
  logic          w_last_y;
  logic          w_cnt_last;

  // Register readback addressed by the byte arriving in CMD1
  always_comb begin
    w_rd = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (spi.byte_dat == 8'(k)) w_rd = r_regs[k*8 +: 8];
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
    if (spi.byte_dat == 8'hFE) w_rd = r_csum;
`endif
  end

  always_comb begin
    w_ch = 8'h00;
    for (int k = 0; k < NUM_CH; k++)
      if (r_regs[7:0] == 8'(k)) w_ch = ch_dat[k*8 +: 8];
  end

  assign w_sh       = (r_sh << 8) | PW'(spi.byte_dat);
  assign w_last_x   = (r_nx == XW'(FRAME_W - 1));
  assign w_last_y   = (r_ny == YW'(FRAME_H - 1));
  assign w_cnt_last = (r_cnt == 4'(BYTES_PER_PIX - 1));

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      r_state <= IDLE;
      r_op    <= 8'h00;
      r_a     <= 8'h00;
      r_feed  <= 8'hFF;
      r_regs  <= '0;
      r_sh    <= '0;
      r_cnt   <= 4'd0;
      r_pv    <= 1'b0;
      r_pd    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_nx    <= '0;
      r_ny    <= '0;
      r_fd    <= 1'b0;
      r_scr   <= 1'b0;
      r_kgate <= 1'b0;
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      r_pv <= 1'b0;
      r_fd <= 1'b0;
      if (!spi.css) begin
        r_state <= IDLE;
        r_cnt   <= 4'd0;
        r_sh    <= '0;
        r_kgate <= 1'b0;
      end else if (spi.byte_rdy) begin
        unique case (r_state)
          IDLE: begin
            r_op    <= spi.byte_dat;
            r_feed  <= 8'hFF;
            r_state <= CMD1;
          end
          CMD1: begin
            r_a     <= spi.byte_dat;
            r_feed  <= (r_op == 8'h81) ? w_rd : 8'hFF;
            r_state <= CMD2;
          end
          CMD2: begin
            r_feed  <= 8'hFF;
            r_state <= DONE;
            case (r_op)
              8'h80: begin
                for (int k = 0; k < NUM_REGS; k++)
                  if (r_a == 8'(k)) r_regs[k*8 +: 8] <= spi.byte_dat;
              end
              8'h55: begin
                r_state <= STREAM;
                r_kgate <= 1'b1;
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
                r_csum  <= 8'h00;
`endif
              end
              8'h40: r_scr <= 1'b0;
              8'h41: begin
                r_scr <= 1'b1;
                r_px  <= '0;
                r_py  <= '0;
                r_nx  <= '0;
                r_ny  <= '0;
              end
              default: ;
            endcase
          end
          DONE: ;
          STREAM: begin
            r_feed <= w_ch;
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
            r_csum <= r_csum ^ spi.byte_dat;
`endif
            if (w_cnt_last) begin
              r_cnt <= 4'd0;
              r_sh  <= '0;
              r_pd  <= w_sh;
              r_pv  <= 1'b1;
              // Screen reset pins the raster at the origin
              if (r_scr) begin
                r_px <= '0;
                r_py <= '0;
              end else begin
                r_px <= r_nx;
                r_py <= r_ny;
                r_fd <= w_last_x && w_last_y;
                if (w_last_x) begin
                  r_nx <= '0;
                  r_ny <= w_last_y ? '0 : r_ny + 1'b1;
                end else begin
                  r_nx <= r_nx + 1'b1;
                end
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
              r_sh  <= w_sh;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi.feed_dat = r_feed;
  assign pix_valid    = r_pv;
  assign pix_dat      = r_pd;
  assign pix_x        = r_px;
  assign pix_y        = r_py;
  assign frame_done   = r_fd;
  assign screen_rst   = r_scr;
  assign kgate        = r_kgate;
  assign reg_q        = r_regs;

endmodule

// File: tb/tb_spi_pixel_bridge.sv
// Randomized bench for spi_pixel_bridge against a transaction-level model.
// Small 4x2 frame so raster wrap and frame_done are exercised often.
module tb_spi_pixel_bridge;
  localparam int NR  = 8;
  localparam int NC  = 8;
  localparam int BPP = 6;
  localparam int FW  = 4;
  localparam int FH  = 2;

  logic        clk_p = 1'b0;
  logic        rst_p;
  logic [63:0] ch_dat;
  logic        pix_valid;
  logic [47:0] pix_dat;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;
  logic        frame_done;
  logic        screen_rst;
  logic        kgate;
  logic [63:0] reg_q;

  always #5 clk_p = ~clk_p;

  spi_pixel_bridge_if spi ();

  spi_pixel_bridge #(
    .NUM_REGS(NR), .NUM_CH(NC), .BYTES_PER_PIX(BPP),
    .FRAME_W(FW), .FRAME_H(FH)
  ) dut (
    .clk_p(clk_p), .rst_p(rst_p), .spi(spi), .ch_dat(ch_dat),
    .pix_valid(pix_valid), .pix_dat(pix_dat), .pix_x(pix_x),
    .pix_y(pix_y), .frame_done(frame_done), .screen_rst(screen_rst),
    .kgate(kgate), .reg_q(reg_q)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: bytes are numbered within a css window
  logic [7:0]  m_regs [NR];
  logic [7:0]  m_feed, m_op, m_a, m_csum;
  logic [47:0] m_pd;
  logic [7:0]  m_stage [$];
  bit          m_pv, m_fd, m_scr, m_stream;
  int          m_x, m_y, m_nx, m_ny, m_idx;

  function automatic logic [7:0] m_read(logic [7:0] a);
    if (a < NR) return m_regs[a];
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
    if (a == 8'hFE) return m_csum;
`endif
    return 8'h00;
  endfunction

  function automatic logic [63:0] m_regq();
    logic [63:0] v;
    for (int k = 0; k < NR; k++) v[k*8 +: 8] = m_regs[k];
    return v;
  endfunction

  always @(posedge clk_p) begin
    logic [7:0] b;
    if (rst_p) begin
      foreach (m_regs[k]) m_regs[k] = 8'h00;
      m_feed = 8'hFF; m_pd = '0; m_pv = 0; m_fd = 0; m_scr = 0;
      m_stream = 0; m_x = 0; m_y = 0; m_nx = 0; m_ny = 0;
      m_idx = 0; m_csum = 0; m_stage.delete();
    end else begin
      m_pv = 0;
      m_fd = 0;
      if (!spi.css) begin
        m_idx = 0;
        m_stage.delete();
        m_stream = 0;
      end else if (spi.byte_rdy) begin
        b = spi.byte_dat;
        if (m_idx == 0) begin
          m_op = b;
          m_feed = 8'hFF;
        end else if (m_idx == 1) begin
          m_a = b;
          m_feed = (m_op == 8'h81) ? m_read(b) : 8'hFF;
        end else if (m_idx == 2) begin
          m_feed = 8'hFF;
          if (m_op == 8'h80 && m_a < NR) m_regs[m_a] = b;
          if (m_op == 8'h55) begin m_stream = 1; m_csum = 0; end
          if (m_op == 8'h40) m_scr = 0;
          if (m_op == 8'h41) begin
            m_scr = 1; m_x = 0; m_y = 0; m_nx = 0; m_ny = 0;
          end
        end else if (m_stream) begin
          m_feed = (m_regs[0] < NC) ? ch_dat[m_regs[0]*8 +: 8] : 8'h00;
          m_csum ^= b;
          m_stage.push_back(b);
          if (m_stage.size() == BPP) begin
            m_pd = '0;
            foreach (m_stage[k]) m_pd = (m_pd << 8) | 48'(m_stage[k]);
            m_pv = 1;
            if (m_scr) begin
              m_x = 0; m_y = 0;
            end else begin
              m_x = m_nx; m_y = m_ny;
              m_fd = (m_nx == FW - 1) && (m_ny == FH - 1);
              m_nx = (m_nx + 1) % FW;
              if (m_nx == 0) m_ny = (m_ny + 1) % FH;
            end
            m_stage.delete();
          end
        end
        if (m_idx < 3) m_idx++;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk_p) begin
    if (chk_en && !rst_p) begin
      chk("feed_dat", 64'(spi.feed_dat), 64'(m_feed));
      chk("pix_valid", 64'(pix_valid), 64'(m_pv));
      chk("pix_dat", 64'(pix_dat), 64'(m_pd));
      chk("pix_x", 64'(pix_x), 64'(m_x));
      chk("pix_y", 64'(pix_y), 64'(m_y));
      chk("frame_done", 64'(frame_done), 64'(m_fd));
      chk("screen_rst", 64'(screen_rst), 64'(m_scr));
      chk("kgate", 64'(kgate), 64'(m_stream));
      chk("reg_q", reg_q, m_regq());
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk_p); #2; end
  endtask

  task automatic send(logic [7:0] b);
    spi.byte_rdy = 1'b1;
    spi.byte_dat = b;
    tick();
    spi.byte_rdy = 1'b0;
  endtask

  task automatic bgn();
    spi.css = 1'b1;
    tick();
  endtask

  task automatic fin();
    spi.css = 1'b0;
    spi.byte_rdy = 1'b0;
    tick(2);
  endtask

  task automatic cmd3(logic [7:0] op, logic [7:0] a, logic [7:0] d);
    bgn(); send(op); send(a); send(d); fin();
  endtask

  task automatic rd(logic [7:0] a);
    bgn(); send(8'h81); send(a); fin();
  endtask

  logic [7:0] exp_cs;

  initial begin
    spi.css = 1'b0; spi.byte_rdy = 1'b0; spi.byte_dat = 8'h00;
    ch_dat = '0;
    rst_p = 1'b1;
    tick(3);
    chk("rst reg_q", reg_q, 64'h0);
    chk("rst feed_dat", 64'(spi.feed_dat), 64'hFF);
    chk("rst pix_valid", 64'(pix_valid), 64'h0);
    chk("rst pix_dat", 64'(pix_dat), 64'h0);
    chk("rst pix_xy", 64'({pix_x, pix_y}), 64'h0);
    chk("rst frame_done", 64'(frame_done), 64'h0);
    chk("rst screen_rst", 64'(screen_rst), 64'h0);
    chk("rst kgate", 64'(kgate), 64'h0);
    rst_p = 1'b0;
    chk_en = 1;
    tick();

    cmd3(8'h80, 8'h03, 8'hA5);
    chk("wr reg3", 64'(reg_q[31:24]), 64'hA5);
    bgn(); send(8'h81); send(8'h03);
    chk("rd reg3", 64'(spi.feed_dat), 64'hA5);
    fin();

    bgn(); send(8'h55); send(8'h00); send(8'h00);
    chk("stream kgate", 64'(kgate), 64'h1);
    for (int i = 1; i <= 12; i++) begin
      send(8'(i));
      if (i == 6) begin
        chk("pix1 valid", 64'(pix_valid), 64'h1);
        chk("pix1 dat", 64'(pix_dat), 64'h010203040506);
        chk("pix1 x", 64'(pix_x), 64'h0);
      end
      if (i == 12) begin
        chk("pix2 dat", 64'(pix_dat), 64'h0708090A0B0C);
        chk("pix2 x", 64'(pix_x), 64'h1);
      end
    end
    for (int p = 3; p <= 9; p++) begin
      for (int j = 0; j < BPP; j++) send(8'($urandom));
      chk("frame pv", 64'(pix_valid), 64'h1);
      chk("frame_done lit", 64'(frame_done), 64'(p == 8));
      if (p == 8) chk("frame end xy", 64'({pix_x, pix_y}), 64'({2'd3, 1'b1}));
      if (p == 9) chk("frame wrap xy", 64'({pix_x, pix_y}), 64'h0);
    end
    fin();

    bgn(); send(8'h55); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    fin();
    chk("abort kgate", 64'(kgate), 64'h0);
    chk("abort pv", 64'(pix_valid), 64'h0);
    bgn(); send(8'h55); send(8'h00); send(8'h00);
    for (int i = 0; i < BPP; i++) send(8'hA0 + 8'(i));
    chk("restart pix", 64'(pix_dat), 64'hA0A1A2A3A4A5);
    fin();

    cmd3(8'h80, 8'h00, 8'h02);
    ch_dat = {$urandom, $urandom};
    ch_dat[23:16] = 8'h3C;
    bgn(); send(8'h55); send(8'h00); send(8'h00); send(8'h11);
    chk("ch2 feed", 64'(spi.feed_dat), 64'h3C);
    fin();
    cmd3(8'h80, 8'h00, 8'h09);
    bgn(); send(8'h55); send(8'h00); send(8'h00); send(8'h22);
    chk("ch oor feed", 64'(spi.feed_dat), 64'h00);
    fin();

    bgn(); send(8'h55); send(8'h00); send(8'h00);
    send(8'h0F); send(8'hF0); send(8'h33);
    fin();
`ifdef SPI_PIXEL_BRIDGE_CSUM_EN
    exp_cs = 8'hCC;
`else
    exp_cs = 8'h00;
`endif
    bgn(); send(8'h81); send(8'hFE);
    chk("csum rd", 64'(spi.feed_dat), 64'(exp_cs));
    fin();

    cmd3(8'h41, 8'h00, 8'h00);
    chk("scr set", 64'(screen_rst), 64'h1);
    bgn(); send(8'h55); send(8'h00); send(8'h00);
    for (int i = 0; i < BPP; i++) send(8'h5A);
    chk("scr pv", 64'(pix_valid), 64'h1);
    chk("scr xy", 64'({pix_x, pix_y, frame_done}), 64'h0);
    fin();
    cmd3(8'h40, 8'h00, 8'h00);

    bgn(); send(8'h55); send(8'h00); send(8'h00);
    for (int i = 0; i < BPP; i++) send(8'h10);
    send(8'h01); send(8'h02);
    rst_p = 1'b1;
    spi.css = 1'b0;
    tick(2);
    rst_p = 1'b0;
    tick();
    bgn(); send(8'h55); send(8'h00); send(8'h00);
    for (int i = 0; i < BPP; i++) send(8'hC0 + 8'(i));
    chk("post rst pix", 64'(pix_dat), 64'hC0C1C2C3C4C5);
    chk("post rst xy", 64'({pix_x, pix_y}), 64'h0);
    fin();

    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        cmd3(8'h80, 8'($urandom_range(0, 10)), 8'($urandom));
      end else if (kind <= 4) begin
        rd(($urandom_range(0, 4) == 0) ? 8'hFE : 8'($urandom_range(0, 10)));
      end else if (kind <= 7) begin
        if ($urandom_range(0, 2) == 0)
          cmd3(8'h80, 8'h00, 8'($urandom_range(0, 9)));
        ch_dat = {$urandom, $urandom};
        bgn(); send(8'h55); send(8'($urandom)); send(8'($urandom));
        for (int n = $urandom_range(0, 20); n > 0; n--) begin
          send(8'($urandom));
          tick($urandom_range(0, 2));
        end
        fin();
      end else if (kind == 8) begin
        cmd3(($urandom_range(0, 3) == 0) ? 8'h41 : 8'h40,
             8'($urandom), 8'($urandom));
      end else begin
        bgn();
        for (int n = $urandom_range(1, 5); n > 0; n--) send(8'($urandom));
        fin();
        spi.byte_rdy = 1'b1;
        spi.byte_dat = 8'h55;
        tick();
        spi.byte_rdy = 1'b0;
      end
    end
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
